// File: rtl/pixel_effects_pkg.sv
// pixel_effects_pkg: effect select codes and frame FSM states shared by the pixel effects engine
package pixel_effects_pkg;
  typedef enum logic [2:0] {
    EFF_NONE      = 3'd0,
    EFF_BRIGHTEN  = 3'd1,
    EFF_DARKEN    = 3'd2,
    EFF_GRAY      = 3'd3,
    EFF_INVERT    = 3'd4,
    EFF_THRESHOLD = 3'd5
  } eff_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/pixel_effects_alu.sv
// pixel_effects_alu: one colour lane (eff, ch, amount in; res, clip out); saturating add/sub, invert, threshold, else pass
module pixel_effects_alu
  import pixel_effects_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic [2:0]      eff,
  input  logic [CH_W-1:0] ch,
  input  logic [CH_W-1:0] amount,
  output logic [CH_W-1:0] res,
  output logic            clip
);
  logic [CH_W:0] sum, diff;
  assign sum  = {1'b0, ch} + {1'b0, amount};
  assign diff = {1'b0, ch} - {1'b0, amount};
  assign res  = eff == EFF_BRIGHTEN  ? (sum[CH_W] ? '1 : sum[CH_W-1:0]) :
                eff == EFF_DARKEN    ? (diff[CH_W] ? '0 : diff[CH_W-1:0]) :
                eff == EFF_INVERT    ? ~ch :
                eff == EFF_THRESHOLD ? {CH_W{ch >= amount}} : ch;
  assign clip = (eff == EFF_BRIGHTEN && sum[CH_W]) || (eff == EFF_DARKEN && diff[CH_W]);
endmodule

// File: rtl/pixel_effects_engine.sv
// pixel_effects_engine: frame copy RAM->effect->RAM (start/eff/amount/rd_data in; rd_*, wr_*, pixel_out, busy, done, sat_count out); sat_count live only with PIXEL_EFFECTS_SAT_CNT_EN
module pixel_effects_engine
  import pixel_effects_pkg::*;
#(
  parameter int CH_W    = 8,
  parameter int NUM_CH  = 3,
  parameter int NUM_PIX = 900,
  parameter int ADDR_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               eff,
  input  logic [CH_W-1:0]          amount,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_CH*CH_W-1:0]   rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NUM_CH*CH_W-1:0]   pixel_out,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          sat_count
);
  state_e state_q, state_d;
  logic drain_q, drain_d, rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
  logic v1_q, v1_d, wr_en_q, wr_en_d;
  logic [2:0] eff_q, eff_d;
  logic [CH_W-1:0] amt_q, amt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, a1_q, a1_d, wr_addr_q, wr_addr_d;
  logic [NUM_CH*CH_W-1:0] res_w, pix_w, pix_q, pix_d;
  logic [NUM_CH-1:0] clip_w;
  logic [CH_W-1:0] gray;
  logic gray_en;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pixel_effects_alu #(.CH_W(CH_W)) u_alu (
      .eff(eff_q), .ch(rd_data[c*CH_W +: CH_W]), .amount(amt_q),
      .res(res_w[c*CH_W +: CH_W]), .clip(clip_w[c])
    );
  end
  if (NUM_CH == 3) begin : g_gray
    assign gray = CH_W'(({2'b0, rd_data[0 +: CH_W]} + {1'b0, rd_data[CH_W +: CH_W], 1'b0}
                        + {2'b0, rd_data[2*CH_W +: CH_W]} + (CH_W+2)'(2)) >> 2);
    assign gray_en = eff_q == EFF_GRAY;
  end else begin : g_nogray
    assign gray = '0;
    assign gray_en = 1'b0;
  end
  assign pix_w = gray_en ? {NUM_CH{gray}} : res_w;
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    eff_d = eff_q;
    amt_d = amt_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        eff_d = eff;
        amt_d = amount;
        rd_addr_d = '0;
      end
      S_RUN: if (rd_addr_q == ADDR_W'(NUM_PIX-1)) begin
        state_d = S_DRAIN;
        drain_d = 1'b0;
      end else rd_addr_d = rd_addr_q + ADDR_W'(1);
      S_DRAIN: begin
        drain_d = 1'b1;
        state_d = drain_q ? S_DONE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
    rd_en_d = state_d == S_RUN;
    busy_d = state_d == S_RUN || state_d == S_DRAIN;
    done_d = state_d == S_DONE;
    v1_d = rd_en_q;
    a1_d = rd_addr_q;
    wr_en_d = v1_q;
    wr_addr_d = v1_q ? a1_q : wr_addr_q;
    pix_d = v1_q ? pix_w : pix_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
      eff_q <= '0;
      amt_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      v1_q <= 1'b0;
      a1_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      eff_q <= eff_d;
      amt_q <= amt_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      v1_q <= v1_d;
      a1_q <= a1_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      pix_q <= pix_d;
    end
  end
`ifdef PIXEL_EFFECTS_SAT_CNT_EN
  logic [ADDR_W:0] sat_q, sat_d;
  always_comb sat_d = (state_q == S_IDLE && start) ? '0 :
                      (v1_q && |clip_w) ? sat_q + (ADDR_W+1)'(1) : sat_q;
  always_ff @(posedge clk) sat_q <= rst ? '0 : sat_d;
  assign sat_count = sat_q;
`else
  logic sat_unused;
  assign sat_unused = ^clip_w;
  assign sat_count = '0;
`endif
  assign rd_en = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign pixel_out = pix_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pixel_effects_engine.sv
// tb_pixel_effects_engine: directed and random frames checked against an arithmetic per-pixel model with cycle-exact handshake checks
module tb_pixel_effects_engine;
  localparam int NP = 4;
`ifdef PIXEL_EFFECTS_SAT_CNT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst, start, rd_en, wr_en, busy, done;
  logic [2:0] eff, rd_addr, wr_addr;
  logic [7:0] amount;
  logic [23:0] rd_data, pixel_out;
  logic [3:0] sat_count;
  logic [23:0] mem [8];
  logic [23:0] wr_log [NP];
  int checks = 0, failures = 0;
  pixel_effects_engine #(.CH_W(8), .NUM_CH(3), .NUM_PIX(NP), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .eff(eff), .amount(amount),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .pixel_out(pixel_out),
    .busy(busy), .done(done), .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [24:0] model(input int e, input int a, input logic [23:0] p);
    int c [3];
    int r, g;
    logic [23:0] o;
    logic cl;
    cl = 1'b0;
    for (int i = 0; i < 3; i++) c[i] = int'(p[8*i +: 8]);
    g = (c[0] + 2*c[1] + c[2] + 2) / 4;
    for (int i = 0; i < 3; i++) begin
      case (e)
        1: begin r = c[i] + a; if (r > 255) begin r = 255; cl = 1'b1; end end
        2: begin r = c[i] - a; if (r < 0) begin r = 0; cl = 1'b1; end end
        3: r = g;
        4: r = 255 - c[i];
        5: r = (c[i] >= a) ? 255 : 0;
        default: r = c[i];
      endcase
      o[8*i +: 8] = 8'(r);
    end
    return {cl, o};
  endfunction
  task automatic fill_random();
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
  endtask
  task automatic run_frame(input logic [2:0] e, input logic [7:0] a);
    int clips;
    logic [24:0] m;
    clips = 0;
    @(negedge clk);
    start = 1'b1;
    eff = e;
    amount = a;
    @(negedge clk);
    for (int k = 1; k <= NP + 4; k++) begin
      if (k > 1) @(negedge clk);
      chk("rd_en", rd_en, k <= NP);
      if (k <= NP) chk("rd_addr", rd_addr, k - 1);
      chk("wr_en", wr_en, k >= 3 && k <= NP + 2);
      if (k >= 3 && k <= NP + 2) begin
        m = model(e, a, mem[k-3]);
        chk("wr_addr", wr_addr, k - 3);
        chk("pixel_out", pixel_out, m[23:0]);
        clips += int'(m[24]);
        wr_log[k-3] = pixel_out;
      end
      chk("busy", busy, k <= NP + 2);
      chk("done", done, k == NP + 3);
      if (k >= NP + 3) chk("sat_count", sat_count, SAT_ON ? clips : 0);
      start = (k < NP + 3) ? 1'($urandom) : 1'b0;
      eff = 3'($urandom);
      amount = 8'($urandom);
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    eff = '0;
    amount = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", {rd_en, wr_en, busy, done, rd_addr, wr_addr, pixel_out, sat_count}, '0);
    rst = 1'b0;
    fill_random();
    mem[0] = {8'd200, 8'd100, 8'd10};
    mem[1] = {8'd230, 8'd0, 8'd0};
    run_frame(3'd1, 8'd50);
    chk("bright_lit0", wr_log[0], {8'd250, 8'd150, 8'd60});
    chk("bright_lit1", wr_log[1], {8'd255, 8'd50, 8'd50});
    fill_random();
    mem[0] = {8'd30, 8'd60, 8'd255};
    run_frame(3'd2, 8'd50);
    chk("darken_lit", wr_log[0], {8'd0, 8'd10, 8'd205});
    fill_random();
    mem[0] = {8'd0, 8'd85, 8'd255};
    run_frame(3'd4, 8'($urandom));
    chk("invert_lit", wr_log[0], {8'd255, 8'd170, 8'd0});
    fill_random();
    mem[0] = {8'd40, 8'd80, 8'd120};
    run_frame(3'd3, 8'($urandom));
    chk("gray_lit", wr_log[0], {8'd80, 8'd80, 8'd80});
    fill_random();
    mem[0] = {8'd127, 8'd128, 8'd200};
    run_frame(3'd5, 8'd128);
    chk("thresh_lit", wr_log[0], {8'd0, 8'd255, 8'd255});
    for (int e = 0; e < 8; e++) begin
      fill_random();
      run_frame(3'(e), 8'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      fill_random();
      run_frame(3'($urandom_range(1, 2)), 8'($urandom));
    end
    fill_random();
    @(negedge clk);
    start = 1'b1;
    eff = 3'd1;
    amount = 8'd50;
    repeat (3) @(negedge clk);
    chk("mid_wr_en", wr_en, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_state", {rd_en, wr_en, busy, done, rd_addr, wr_addr, pixel_out, sat_count}, '0);
    rst = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_quiet", {wr_en, done, busy, rd_en}, '0);
    end
    run_frame(3'd1, 8'd50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
